// File: rtl/bcd_display_pkg.sv
// Shared definitions for the two-digit BCD display driver: slot states and
// active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD to active-high seven-segment encoder; codes above 9
// render as a dash so corrupt decoder output is visible on the display.
module seg7_encoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver: shadow/active digit registers,
// a four-slot FSM with guard intervals, and registered segment/enable outputs.
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD        = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an
);
  import bcd_display_pkg::*;

  localparam int            CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - GUARD - 1);
  localparam logic [6:0]    SEG_IDLE   = COMMON_ANODE ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0]    AN_IDLE    = COMMON_ANODE ? 2'b11 : 2'b00;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic [3:0]    sh0_q, sh1_q, sh0_d, sh1_d;
  logic [3:0]    act0_q, act1_q, act0_d, act1_d;
  logic [6:0]    seg_q, seg_d, segRaw, segOn;
  logic [1:0]    an_q, an_d, anOn;
  logic [3:0]    encDigit;

  // run_q holds the FSM at BLANK0/cnt 0 for the first edge after reset so
  // that a full guard interval precedes the first digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    act0_d  = act0_q;
    act1_d  = act1_q;
    if (!run_q) begin
      state_d = BLANK0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK0: if (cnt_q == GUARD_LAST) begin state_d = SHOW0;  cnt_d = '0; end
        SHOW0:  if (cnt_q == SHOW_LAST)  begin state_d = BLANK1; cnt_d = '0; end
        BLANK1: if (cnt_q == GUARD_LAST) begin state_d = SHOW1;  cnt_d = '0; end
        SHOW1: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK0;
            cnt_d   = '0;
            act0_d  = sh0_q;
            act1_d  = sh1_q;
          end
        end
        default: begin state_d = BLANK0; cnt_d = '0; end
      endcase
    end
  end

  assign sh0_d    = load ? in0 : sh0_q;
  assign sh1_d    = load ? in1 : sh1_q;
  assign encDigit = (state_d == SHOW1) ? act1_d : act0_d;

  seg7_encoder u_enc (
    .bcd_i (encDigit),
    .seg_o (segRaw)
  );

  // Outputs are decoded from the next state so they switch with the state.
  always_comb begin
    segOn = SEG_OFF;
    anOn  = 2'b00;
    if (state_d == SHOW0) begin
      segOn = segRaw;
      anOn  = 2'b01;
    end else if (state_d == SHOW1 && !(blank_lz && act1_d == 4'd0)) begin
      segOn = segRaw;
      anOn  = 2'b10;
    end
    seg_d = COMMON_ANODE ? ~segOn : segOn;
    an_d  = COMMON_ANODE ? ~anOn  : anOn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      sh0_q   <= 4'd0;
      sh1_q   <= 4'd0;
      act0_q  <= 4'd0;
      act1_q  <= 4'd0;
      seg_q   <= SEG_IDLE;
      an_q    <= AN_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
